vic_regs: RTL and testbench

- CPU-side register file for the 6560-style video chip at CPU $9000-$900F.
- Written by the 6502 bus; it is the configuration writer for the video generator.
- Translates register contents into the video block's configuration inputs: screen_addr, char_rom_addr, color_ram_addr, border/back/aux colours and the inverted flag.
- Returns live raster position and light-pen latches on reads; outputs are shadowed per frame so the picture never tears mid-frame.

---
 rtl/vic_regs.sv | 186 ++++++++++++++++++
 tb/tb_vic_regs.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vic_regs.sv
// vic_regs: CPU-side register file ($9000-$900F) for the 6560-style video chip.
// Turns register contents into per-frame shadowed configuration for the video generator.
// It returns the live raster position and the light-pen latches on reads.
//
// Optional feature: define RASTER_IRQ_EN to add the raster compare interrupt.
//   Defined:   writes to $4 set a compare value, and irq is raised on a raster match.
//   Undefined: writes to $4 are ignored, and irq is tied to 0.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   cpu_cs/we/addr/din  6502 register access; cpu_dout is registered read data (1-cycle latency)
//   raster_line/x       live raster position from the video generator
//   frame_start         one-cycle pulse at frame start; loads the configuration shadows
//   light_pen           asynchronous active-low light-pen strobe
//   screen_addr, char_rom_addr, color_ram_addr, border_color, back_color, aux_color,
//   inverted, columns, rows    shadowed configuration outputs
//   irq                 raster interrupt
module vic_regs #(
  parameter int unsigned LP_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic [8:0]  raster_line,
  input  logic [7:0]  raster_x,
  input  logic        frame_start,
  input  logic        light_pen,
  output logic [15:0] screen_addr,
  output logic [15:0] char_rom_addr,
  output logic [15:0] color_ram_addr,
  output logic [2:0]  border_color,
  output logic [3:0]  back_color,
  output logic [3:0]  aux_color,
  output logic        inverted,
  output logic [6:0]  columns,
  output logic [5:0]  rows,
  output logic        irq
);

  logic [7:0] r_q [16];
  logic [7:0] r_d [16];
  logic       wr_en;
  logic       rd_en;
  logic [7:0] rd_data;

  // Light-pen state. Only lp_y[8:1] is ever visible, so only those bits are kept.
  logic [LP_SYNC_STAGES-1:0] lp_sync_q;
  logic                      lp_prev_q;
  logic                      lp_edge;
  logic                      lp_armed_q;
  logic [7:0]                lp_x_q;
  logic [7:0]                lp_y_q;

  // Decoded configuration (from post-write register values, so frame_start writes through).
  logic [13:0] scr_va;
  logic [13:0] chr_va;
  logic [15:0] scr_cpu;
  logic [15:0] chr_cpu;
  logic [15:0] col_cpu;

  // $4 is never a plain register; $6..$9 are read-only.
  assign wr_en = cpu_cs && cpu_we && (cpu_addr != 4'd4) &&
                 !((cpu_addr >= 4'd6) && (cpu_addr <= 4'd9));
  assign rd_en = cpu_cs && !cpu_we;

  always_comb begin
    for (int i = 0; i < 16; i++) r_d[i] = r_q[i];
    if (wr_en) r_d[cpu_addr] = cpu_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_q[i] <= 8'h00;
      r_q[2]  <= 8'h96;
      r_q[5]  <= 8'hF0;
      r_q[15] <= 8'h1B;
    end else begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
    end
  end

  // VIC 14-bit address to CPU address: VIC A13 low selects the $8000 block.
  always_comb begin
    scr_va  = {r_d[5][7:4], r_d[2][7], 9'b0};
    chr_va  = {r_d[5][3:0], 10'b0};
    scr_cpu = {~scr_va[13], 2'b00, scr_va[12:0]};
    chr_cpu = {~chr_va[13], 2'b00, chr_va[12:0]};
    col_cpu = 16'h9400 | (r_d[2][7] ? 16'h0200 : 16'h0000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      screen_addr    <= 16'h1E00;
      char_rom_addr  <= 16'h8000;
      color_ram_addr <= 16'h9600;
      border_color   <= 3'd3;
      back_color     <= 4'd1;
      aux_color      <= 4'd0;
      inverted       <= 1'b1;
      columns        <= 7'd22;
      rows           <= 6'd0;
    end else if (frame_start) begin
      screen_addr    <= scr_cpu;
      char_rom_addr  <= chr_cpu;
      color_ram_addr <= col_cpu;
      border_color   <= r_d[15][2:0];
      inverted       <= r_d[15][3];
      back_color     <= r_d[15][7:4];
      aux_color      <= r_d[14][7:4];
      columns        <= r_d[2][6:0];
      rows           <= r_d[3][6:1];
    end
  end

  // Light pen: synchroniser, then falling-edge detect; first edge per frame wins.
  assign lp_edge = lp_prev_q && !lp_sync_q[LP_SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lp_sync_q  <= '1;
      lp_prev_q  <= 1'b1;
      lp_armed_q <= 1'b1;
      lp_x_q     <= 8'h00;
      lp_y_q     <= 8'h00;
    end else begin
      lp_sync_q <= {lp_sync_q[LP_SYNC_STAGES-2:0], light_pen};
      lp_prev_q <= lp_sync_q[LP_SYNC_STAGES-1];
      if (lp_edge && lp_armed_q) begin
        lp_x_q     <= raster_x;
        lp_y_q     <= raster_line[8:1];
        lp_armed_q <= frame_start;
      end else if (frame_start) begin
        lp_armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = r_q[cpu_addr];
    case (cpu_addr)
      4'd3:        rd_data = {raster_line[0], r_q[3][6:0]};
      4'd4:        rd_data = raster_line[8:1];
      4'd6:        rd_data = lp_x_q;
      4'd7:        rd_data = lp_y_q;
      4'd8, 4'd9:  rd_data = 8'hFF;
      default:     rd_data = r_q[cpu_addr];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cpu_dout <= 8'h00;
    else if (rd_en) cpu_dout <= rd_data;
  end

`ifdef RASTER_IRQ_EN
  logic [7:0] cmp_q;
  logic       match;
  logic       match_q;
  logic       irq_q;

  assign match = (raster_line[8:1] == cmp_q) && (cmp_q != 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_q   <= 8'h00;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (cpu_cs && cpu_we && (cpu_addr == 4'd4)) cmp_q <= cpu_din;
      match_q <= match;
      // Set has priority over a same-cycle clear by reading $4.
      if (match && !match_q) irq_q <= 1'b1;
      else if (rd_en && (cpu_addr == 4'd4)) irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vic_regs.sv
module tb_vic_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_we;
  logic [3:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic [8:0]  raster_line;
  logic [7:0]  raster_x;
  logic        frame_start;
  logic        light_pen;
  logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
  logic [2:0]  border_color;
  logic [3:0]  back_color, aux_color;
  logic        inverted;
  logic [6:0]  columns;
  logic [5:0]  rows;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  vic_regs #(.LP_SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .raster_line(raster_line), .raster_x(raster_x),
    .frame_start(frame_start), .light_pen(light_pen), .screen_addr(screen_addr),
    .char_rom_addr(char_rom_addr), .color_ram_addr(color_ram_addr),
    .border_color(border_color), .back_color(back_color), .aux_color(aux_color),
    .inverted(inverted), .columns(columns), .rows(rows), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [8:0] line;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [3:0] a, logic [7:0] d, logic [8:0] l,
                              logic chk, logic [7:0] e);
    vec_t v;
    v.we = we; v.addr = a; v.din = d; v.line = l; v.chk = chk; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle; outputs sampled 1 time unit after the edge.
  task automatic bus(input logic we, input logic [3:0] a, input logic [7:0] d, input logic fs);
    cpu_cs = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; frame_start = fs;
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pen_pulse(input logic [7:0] x, input logic [8:0] line);
    raster_x = x; raster_line = line;
    light_pen = 1'b0;
    repeat (5) tick();
    light_pen = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    reset = 1'b1; cpu_cs = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
    raster_line = 0; raster_x = 0; frame_start = 0; light_pen = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst screen_addr", screen_addr, 16'h1E00);
    check("rst char_rom_addr", char_rom_addr, 16'h8000);
    check("rst color_ram_addr", color_ram_addr, 16'h9600);
    check("rst border", border_color, 3);
    check("rst back", back_color, 1);
    check("rst aux", aux_color, 0);
    check("rst inverted", inverted, 1);
    check("rst columns", columns, 22);
    check("rst rows", rows, 0);
    check("rst cpu_dout", cpu_dout, 0);
    check("rst irq", irq, 0);

    // Register-level read/write vectors
    vecs.push_back(mk(0, 4'hF, 8'h00, 9'h000, 1, 8'h1B));
    vecs.push_back(mk(0, 4'h2, 8'h00, 9'h000, 1, 8'h96));
    vecs.push_back(mk(0, 4'h5, 8'h00, 9'h000, 1, 8'hF0));
    vecs.push_back(mk(0, 4'h0, 8'h00, 9'h000, 1, 8'h00));
    vecs.push_back(mk(1, 4'hA, 8'h33, 9'h000, 0, 8'h00));
    vecs.push_back(mk(0, 4'hA, 8'h00, 9'h000, 1, 8'h33));
    vecs.push_back(mk(1, 4'h6, 8'h55, 9'h000, 0, 8'h00));
    vecs.push_back(mk(0, 4'h6, 8'h00, 9'h000, 1, 8'h00));
    vecs.push_back(mk(1, 4'h8, 8'h12, 9'h000, 0, 8'h00));
    vecs.push_back(mk(0, 4'h8, 8'h00, 9'h000, 1, 8'hFF));
    vecs.push_back(mk(0, 4'h9, 8'h00, 9'h000, 1, 8'hFF));
    vecs.push_back(mk(0, 4'h3, 8'h00, 9'h135, 1, 8'h80));
    vecs.push_back(mk(0, 4'h4, 8'h00, 9'h135, 1, 8'h9A));
    vecs.push_back(mk(1, 4'h3, 8'h0E, 9'h135, 0, 8'h00));
    vecs.push_back(mk(0, 4'h3, 8'h00, 9'h135, 1, 8'h8E));
    vecs.push_back(mk(0, 4'h3, 8'h00, 9'h134, 1, 8'h0E));
    vecs.push_back(mk(0, 4'h7, 8'h00, 9'h000, 1, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      raster_line = vecs[i].line;
      bus(vecs[i].we, vecs[i].addr, vecs[i].din, 1'b0);
      if (vecs[i].chk) check($sformatf("vec%0d read $%0h", i, vecs[i].addr), cpu_dout,
                             vecs[i].exp);
    end

    // Mid-frame writes stay invisible until frame_start
    bus(1, 4'h5, 8'hCC, 0);
    bus(1, 4'h2, 8'h16, 0);
    tick();
    check("shadow hold screen", screen_addr, 16'h1E00);
    check("shadow hold color", color_ram_addr, 16'h9600);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("frame screen_addr", screen_addr, 16'h1000);
    check("frame char_rom_addr", char_rom_addr, 16'h1000);
    check("frame color_ram_addr", color_ram_addr, 16'h9400);
    check("frame columns", columns, 22);
    check("frame rows", rows, 7);

    // Write coinciding with frame_start goes straight through
    bus(1, 4'hF, 8'h08, 1);
    check("wt border", border_color, 0);
    check("wt back", back_color, 0);
    check("wt inverted", inverted, 1);

    // Light pen: first edge per frame latches, second is ignored
    pen_pulse(8'h40, 9'd100);
    pen_pulse(8'h55, 9'd120);
    bus(0, 4'h6, 8'h00, 0);
    check("lp x first", cpu_dout, 8'h40);
    bus(0, 4'h7, 8'h00, 0);
    check("lp y first", cpu_dout, 8'h32);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pen_pulse(8'h11, 9'd120);
    bus(0, 4'h7, 8'h00, 0);
    check("lp y rearm", cpu_dout, 8'h3C);
    bus(0, 4'h6, 8'h00, 0);
    check("lp x rearm", cpu_dout, 8'h11);

    // Raster compare interrupt
    begin
      int first_line;
      first_line = -1;
      raster_line = 9'd0;
      bus(1, 4'h4, 8'h50, 0);
      for (int l = 150; l <= 170; l++) begin
        raster_line = l[8:0];
        tick();
        if (irq && first_line < 0) first_line = l;
      end
`ifdef RASTER_IRQ_EN
      check("irq first line", first_line, 160);
      check("irq held", irq, 1);
      bus(0, 4'h4, 8'h00, 0);
      check("irq read $4 raster", cpu_dout, 8'h55);
      check("irq cleared", irq, 0);
`else
      check("irq stays low", first_line, -1);
      bus(0, 4'h4, 8'h00, 0);
      check("read $4 raster", cpu_dout, 8'h55);
      check("irq low after read", irq, 0);
`endif
    end

    // Reset mid-read restores everything at once
    bus(0, 4'hF, 8'h00, 0);
    check("pre-reset read $F", cpu_dout, 8'h08);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h2;
    #2 reset = 1'b1;
    #1;
    check("async rst dout", cpu_dout, 0);
    check("async rst screen", screen_addr, 16'h1E00);
    check("async rst border", border_color, 3);
    cpu_cs = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    bus(0, 4'h5, 8'h00, 0);
    check("post-reset R5", cpu_dout, 8'hF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
